// File: rtl/cfi_instr_encoder.sv
// cfi_instr_encoder
//   Turns abstract CFI requests (op + label) into legal 32-bit CFI instruction
//   words for the debug instruction-injection path. Requests are queued in a
//   small FIFO. Each word is presented on a registered valid/ready stream and
//   can be followed by PAD_NOPS padding NOPs.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drop queued requests, abort the current word or padding
//   req_valid_i     request valid; req_ready_o = FIFO not full (registered)
//   req_op_i        0 LPCLL, 1 LPSLL, 2 SML, 3 CML, 4 SUL, 5 CUL, 6-7 illegal
//   req_label_i     9-bit label; ops 2-5 use [7:0] and require [8]=0
//   instr_valid_o   instr_o valid; instr_ready_i downstream accepts
//   instr_o         encoded word (or NOP while padding)
//   is_pad_o        current word is a padding NOP
//   err_o           sticky request error; err_clr_i clears it (a new error wins)
module cfi_instr_encoder #(
  parameter int DEPTH    = 4,
  parameter int PAD_NOPS = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [8:0]  req_label_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        is_pad_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, EMIT, PAD} state_e;

  state_e      state_q;
  logic [11:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic        full_q;
  logic [3:0]  pad_cnt_q;
  logic        err_q;

  logic        empty, accept, bad, push, pop, load_next, hs;
  logic [11:0] head;

  function automatic logic illegal_req(input logic [2:0] op, input logic [8:0] label);
    return (op > 3'd5) || ((op >= 3'd2) && label[8]);
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] op, input logic [8:0] label);
    logic [31:0] w;
    w[14:0] = {3'b100, 5'b00000, 7'b1110011};
    if (op < 3'd2)
      w[31:15] = {7'b1000001, (op == 3'd0), label};
    else
      // op[2] separates SUL/CUL from SML/CML, op[0] selects the "clear" variant
      w[31:15] = {7'b1000011, op[2], op[0], label[7:0]};
    return w;
  endfunction

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign req_ready_o = !full_q;
  assign accept      = req_valid_i && !full_q;
  assign bad         = accept && illegal_req(req_op_i, req_label_i);
  assign push        = accept && !bad && !flush_i;
  assign hs          = instr_valid_o && instr_ready_i;
  assign head        = fifo_mem[rd_ptr_q[AW-1:0]];
  assign pop         = load_next && !flush_i;
  assign err_o       = err_q;

  // Decide whether the output register takes the FIFO head this cycle
  always_comb begin
    load_next = 1'b0;
    case (state_q)
      IDLE:    load_next = !empty;
      EMIT:    load_next = hs && (PAD_NOPS == 0) && !empty;
      PAD:     load_next = hs && (pad_cnt_q == 4'd1) && !empty;
      default: load_next = 1'b0;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // FIFO control; full is registered from the next-state pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= ((wr_ptr_d - rd_ptr_d) == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {req_op_i, req_label_i};
  end

  // Output stage: IDLE -> EMIT -> (PAD) -> next word or IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      is_pad_o      <= 1'b0;
      pad_cnt_q     <= '0;
    end else if (flush_i) begin
      state_q       <= IDLE;
      instr_valid_o <= 1'b0;
      is_pad_o      <= 1'b0;
      pad_cnt_q     <= '0;
    end else if (load_next) begin
      state_q       <= EMIT;
      instr_valid_o <= 1'b1;
      instr_o       <= encode(head[11:9], head[8:0]);
      is_pad_o      <= 1'b0;
    end else begin
      case (state_q)
        EMIT: begin
          if (hs) begin
            if (PAD_NOPS > 0) begin
              state_q   <= PAD;
              pad_cnt_q <= 4'(PAD_NOPS);
              instr_o   <= NOP;
              is_pad_o  <= 1'b1;
            end else begin
              state_q       <= IDLE;
              instr_valid_o <= 1'b0;
            end
          end
        end
        PAD: begin
          if (hs) begin
            if (pad_cnt_q == 4'd1) begin
              state_q       <= IDLE;
              instr_valid_o <= 1'b0;
              is_pad_o      <= 1'b0;
            end else begin
              pad_cnt_q <= pad_cnt_q - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky error: a new error in the same cycle as a clear keeps err set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        err_q <= 1'b0;
    else if (bad)       err_q <= 1'b1;
    else if (err_clr_i) err_q <= 1'b0;
  end

endmodule

// File: tb/tb_cfi_instr_encoder.sv
module tb_cfi_instr_encoder;
  localparam int DEPTH = 4;
  localparam int PADN  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, req_valid, instr_ready, err_clr;
  logic [2:0]  req_op;
  logic [8:0]  req_label;
  logic        rdy0, v0, pad0, err0, rdy1, v1, pad1, err1;
  logic [31:0] w0, w1;

  int errors = 0;
  int checks = 0;

  // Expected words still to come out of each DUT: {is_pad, word}
  logic [32:0] exp0[$], exp1[$], obs0[$], obs1[$];
  logic        errm[2], stall[2], stall_p[2], set_pend[2];
  logic [31:0] stall_w[2];
  int          acc[2];
  logic [8:0]  lbl[2];

  cfi_instr_encoder #(.DEPTH(DEPTH), .PAD_NOPS(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(rdy0), .req_op_i(req_op), .req_label_i(req_label),
    .instr_valid_o(v0), .instr_ready_i(instr_ready), .instr_o(w0),
    .is_pad_o(pad0), .err_o(err0), .err_clr_i(err_clr));

  cfi_instr_encoder #(.DEPTH(DEPTH), .PAD_NOPS(PADN)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(rdy1), .req_op_i(req_op), .req_label_i(req_label),
    .instr_valid_o(v1), .instr_ready_i(instr_ready), .instr_o(w1),
    .is_pad_o(pad1), .err_o(err1), .err_clr_i(err_clr));

  task automatic chk(input string tag, input logic [32:0] o, input logic [32:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic is_illegal(input logic [2:0] op, input logic [8:0] lb);
    return (op > 3'd5) || ((op >= 3'd2) && lb[8]);
  endfunction

  // Word built arithmetically from the field values
  function automatic logic [32:0] model_word(input logic [2:0] op, input logic [8:0] lb);
    logic [31:0] w;
    w = 32'h0000_4073;
    if (op <= 3'd1) begin
      w = w + 32'h8200_0000 + ((op == 3'd0) ? 32'h0100_0000 : 32'h0) + (32'(lb) << 15);
    end else begin
      w = w + 32'h8600_0000 + ((op >= 3'd4) ? 32'h0100_0000 : 32'h0)
            + (((op == 3'd3) || (op == 3'd5)) ? 32'h0080_0000 : 32'h0)
            + ((32'(lb) % 32'd256) << 15);
    end
    return {1'b0, w};
  endfunction

  function automatic int cfi_cnt(input int d);
    int n = 0;
    if (d == 0) begin foreach (exp0[i]) if (!exp0[i][32]) n++; end
    else        begin foreach (exp1[i]) if (!exp1[i][32]) n++; end
    return n;
  endfunction

  task automatic pre(input int d);
    logic r, v, p;
    logic [31:0] w;
    logic [32:0] front;
    int sz;
    r = (d == 0) ? rdy0 : rdy1;
    v = (d == 0) ? v0 : v1;
    p = (d == 0) ? pad0 : pad1;
    w = (d == 0) ? w0 : w1;
    if (stall[d]) begin
      chk("hold_valid", 33'(v), 33'd1);
      chk("hold_word", {p, w}, {stall_p[d], stall_w[d]});
    end
    stall[d]   = v && !instr_ready && !flush;
    stall_w[d] = w;
    stall_p[d] = p;
    if (!r) chk("ready_low_only_when_full", 33'(cfi_cnt(d) >= DEPTH), 33'd1);
    set_pend[d] = req_valid && r && is_illegal(req_op, req_label);
    if (flush) begin
      if (d == 0) exp0.delete(); else exp1.delete();
    end else begin
      if (v && instr_ready) begin
        sz = (d == 0) ? exp0.size() : exp1.size();
        chk("out_expected", 33'(sz > 0), 33'd1);
        if (sz > 0) begin
          front = (d == 0) ? exp0.pop_front() : exp1.pop_front();
          chk("out_word", {p, w}, front);
        end
        if (d == 0) obs0.push_back({p, w}); else obs1.push_back({p, w});
      end
      if (req_valid && r && !is_illegal(req_op, req_label)) begin
        acc[d]++;
        if (d == 0) exp0.push_back(model_word(req_op, req_label));
        else begin
          exp1.push_back(model_word(req_op, req_label));
          for (int k = 0; k < PADN; k++) exp1.push_back({1'b1, 32'h0000_0013});
        end
      end
    end
  endtask

  task automatic post(input int d);
    errm[d] = set_pend[d] ? 1'b1 : (err_clr ? 1'b0 : errm[d]);
    chk("err", 33'((d == 0) ? err0 : err1), 33'(errm[d]));
  endtask

  task automatic tick();
    pre(0); pre(1);
    @(posedge clk);
    @(negedge clk);
    post(0); post(1);
  endtask

  task automatic clear_model();
    exp0.delete(); exp1.delete();
    for (int d = 0; d < 2; d++) begin
      errm[d] = 1'b0; stall[d] = 1'b0; set_pend[d] = 1'b0; acc[d] = 0;
    end
  endtask

  task automatic drain();
    req_valid = 1'b0; flush = 1'b0; err_clr = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 200 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
    tick(); tick();
    chk("drain0", 33'(exp0.size()), 33'd0);
    chk("drain1", 33'(exp1.size()), 33'd0);
    chk("idle_valid0", 33'(v0), 33'd0);
    chk("idle_valid1", 33'(v1), 33'd0);
  endtask

  task automatic push_req(input logic [2:0] op, input logic [8:0] lb);
    req_valid = 1'b1; req_op = op; req_label = lb;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; instr_ready = 1'b0;
    err_clr = 1'b0; req_op = '0; req_label = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 33'(v0), 33'd0);
    chk("rst_instr", 33'(w0), 33'd0);
    chk("rst_pad", 33'(pad0), 33'd0);
    chk("rst_err", 33'(err0), 33'd0);
    chk("rst_ready", 33'(rdy0), 33'd1);
    chk("rst_ready_pad", 33'(rdy1), 33'd1);

    // LPCLL 0x1A5, word one cycle after push
    instr_ready = 1'b1;
    push_req(3'd0, 9'h1A5);
    tick();
    chk("lpcll_valid", 33'(v0), 33'd1);
    chk("lpcll_word", 33'(w0), 33'h0_83D2_C073);
    drain();

    // SML / CUL back to back, in request order
    obs0.delete();
    req_valid = 1'b1; req_op = 3'd2; req_label = 9'h03C; tick();
    req_op = 3'd5; req_label = 9'h0FF; tick();
    drain();
    chk("seq_count", 33'(obs0.size()), 33'd2);
    chk("sml_word", obs0[0], 33'h0_861E_4073);
    chk("cul_word", obs0[1], 33'h0_87FF_C073);

    // Backpressure fills the queue
    instr_ready = 1'b0; acc[0] = 0; acc[1] = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_op = 3'(i % 2); req_label = 9'(i * 37 + 5);
      tick();
    end
    req_valid = 1'b0;
    chk("full_ready0", 33'(rdy0), 33'd0);
    chk("full_ready1", 33'(rdy1), 33'd0);
    chk("fill_count", 33'((acc[0] == DEPTH) || (acc[0] == DEPTH + 1)), 33'd1);
    drain();

    // Illegal requests
    obs0.delete();
    push_req(3'd7, 9'h000);
    chk("err_op7", 33'(err0), 33'd1);
    tick(); tick(); tick();
    chk("err_no_out", 33'(obs0.size()), 33'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr", 33'(err0), 33'd0);
    push_req(3'd2, 9'h100);
    chk("err_sml_lbl8", 33'(err0), 33'd1);
    tick(); tick();
    chk("err_no_out2", 33'(obs0.size()), 33'd0);
    req_valid = 1'b1; req_op = 3'd6; req_label = 9'h0; err_clr = 1'b1; tick();
    req_valid = 1'b0; err_clr = 1'b0;
    chk("err_set_wins", 33'(err0), 33'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Padding pattern
    obs1.delete();
    lbl[0] = 9'h055; lbl[1] = 9'h1F0;
    instr_ready = 1'b1;
    push_req(3'd1, lbl[0]);
    push_req(3'd1, lbl[1]);
    drain();
    chk("pad_count", 33'(obs1.size()), 33'd6);
    for (int i = 0; i < 6; i++)
      chk("pad_seq", obs1[i], (i % 3 == 0) ? model_word(3'd1, lbl[i / 3]) : {1'b1, 32'h0000_0013});

    // Flush while padding with three requests queued
    instr_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd1;
    for (int i = 0; i < 4; i++) begin req_label = 9'(i + 9'h40); tick(); end
    req_valid = 1'b0; instr_ready = 1'b1; tick();
    instr_ready = 1'b0;
    chk("in_pad", 33'(pad1), 33'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_valid0", 33'(v0), 33'd0);
    chk("flush_valid1", 33'(v1), 33'd0);
    chk("flush_ready1", 33'(rdy1), 33'd1);
    tick(); tick();
    chk("flush_empty1", 33'(v1), 33'd0);
    chk("flush_empty0", 33'(v0), 33'd0);
    instr_ready = 1'b1;
    push_req(3'd5, 9'h0AB);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
      req_label = 9'($urandom_range(0, 511));
      if (req_op >= 3'd2 && $urandom_range(0, 5) != 0) req_label[8] = 1'b0;
      instr_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if (flush) instr_ready = 1'b0;
      err_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    drain();
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Asynchronous reset in the middle of a stream
    instr_ready = 1'b0;
    push_req(3'd0, 9'h011);
    push_req(3'd3, 9'h022);
    push_req(3'd4, 9'h033);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid0", 33'(v0), 33'd0);
    chk("arst_instr0", 33'(w0), 33'd0);
    chk("arst_valid1", 33'(v1), 33'd0);
    chk("arst_pad1", 33'(pad1), 33'd0);
    chk("arst_ready0", 33'(rdy0), 33'd1);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    instr_ready = 1'b1;
    push_req(3'd2, 9'h0C3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
